memory_arbiter: RTL and testbench

Single-port memory arbiter between the pipelined datapath's instruction-fetch and data-access request lines and the shared RAM. It serializes instruction and data requests onto one RAM port, grants data priority, and returns the one-cycle `ihit` and `dhit` pulses. The hazard unit consumes these pulses to drive latch enables and flushes.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/memory_arbiter_if.sv | 39 +++
 rtl/sat_counter.sv | 38 +++
 rtl/memory_arbiter.sv | 131 +++++++++++++
 tb/tb_memory_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// +-----------------------------------------------------------------------+
// | cpu_types_pkg : shared CPU word, RAM-state and arbiter-state types     |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t IGNT = 2'd1;
  localparam arb_state_t DGNT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/memory_arbiter_if.sv
// +-----------------------------------------------------------------------+
// | memory_arbiter_if : arbiter signal bundle (ma = arbiter, dp = datapath)|
// | Revision          : 1.0                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  logic      dREN;
  logic      dWEN;
  logic      ihit;
  logic      dhit;
  logic      ramREN;
  logic      ramWEN;
  word_t     iaddr;
  word_t     daddr;
  word_t     dstore;
  word_t     iload;
  word_t     dload;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport ma (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport dp (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ihit, dhit, iload, dload
  );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// +-----------------------------------------------------------------------+
// | sat_counter : event counter that sticks at all-ones                   |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// +-----------------------------------------------------------------------+
// | memory_arbiter : single-port RAM arbiter, data has priority over fetch|
// | Option MEMORY_ARBITER_STATS_EN adds icount/dcount/wait_cycles outputs |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output logic              ihit,
  output logic              dhit,
  output word_t             iload,
  output word_t             dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  ramstate_t         ramstate
`ifdef MEMORY_ARBITER_STATS_EN
  ,
  output word_t             icount,
  output word_t             dcount,
  output word_t             wait_cycles
`endif
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       access;
  logic       dreq;

  assign access = (ramstate == ACCESS);
  assign dreq   = dREN | dWEN;

  // A grant ends on ACCESS or when its request is withdrawn; never preempted.
  always_comb begin
    state_d  = state_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        if (dreq) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      DGNT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (access) begin
          dhit    = 1'b1;
          dload   = ramload;
          state_d = IDLE;
        end else if (!dreq) begin
          state_d = IDLE;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (access) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_d = IDLE;
        end else if (!iREN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEMORY_ARBITER_STATS_EN
  logic wait_inc;

  assign wait_inc = (state_q != IDLE) && !access;

  sat_counter #(.WIDTH(WORD_W)) u_icount (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (ihit),
    .count (icount)
  );

  sat_counter #(.WIDTH(WORD_W)) u_dcount (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (dhit),
    .count (dcount)
  );

  sat_counter #(.WIDTH(WORD_W)) u_wait_cycles (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (wait_inc),
    .count (wait_cycles)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_memory_arbiter : directed + randomized check against a grant model |
// | Revision          : 1.0                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN;
  logic      dREN;
  logic      dWEN;
  word_t     iaddr;
  word_t     daddr;
  word_t     dstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ihit;
  logic      dhit;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
`ifdef MEMORY_ARBITER_STATS_EN
  word_t     icount;
  word_t     dcount;
  word_t     wait_cycles;
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  int    owner   = OWN_NONE;
  logic  exp_ihit = 1'b0;
  logic  exp_dhit = 1'b0;
  word_t m_icount = '0;
  word_t m_dcount = '0;
  word_t m_wait   = '0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.ADDR_W(32)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .ihit        (ihit),
    .dhit        (dhit),
    .iload       (iload),
    .dload       (dload),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (ramstate)
`ifdef MEMORY_ARBITER_STATS_EN
    ,
    .icount      (icount),
    .dcount      (dcount),
    .wait_cycles (wait_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic word_t sat_add(input word_t v, input logic inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // One clock: check outputs mid-cycle against the owner model, then advance it.
  task automatic cycle();
    logic  acc;
    logic  e_ren;
    logic  e_wen;
    word_t e_addr;
    word_t e_store;
    word_t e_iload;
    word_t e_dload;
    @(negedge CLK);
    acc      = (ramstate == ACCESS);
    e_ren    = 1'b0;
    e_wen    = 1'b0;
    e_addr   = '0;
    e_store  = '0;
    e_iload  = '0;
    e_dload  = '0;
    exp_ihit = 1'b0;
    exp_dhit = 1'b0;
    if (owner == OWN_D) begin
      e_ren    = dREN;
      e_wen    = dWEN;
      e_addr   = daddr;
      e_store  = dstore;
      exp_dhit = acc;
      e_dload  = acc ? ramload : '0;
    end else if (owner == OWN_I) begin
      e_ren    = iREN;
      e_addr   = iaddr;
      exp_ihit = acc;
      e_iload  = acc ? ramload : '0;
    end
    check_eq("ihit", ihit, exp_ihit);
    check_eq("dhit", dhit, exp_dhit);
    check_eq("iload", iload, e_iload);
    check_eq("dload", dload, e_dload);
    check_eq("ramREN", ramREN, e_ren);
    check_eq("ramWEN", ramWEN, e_wen);
    check_eq("ramaddr", ramaddr, e_addr);
    check_eq("ramstore", ramstore, e_store);
    check_eq("hit_exclusive", ihit & dhit, 1'b0);
`ifdef MEMORY_ARBITER_STATS_EN
    check_eq("icount", icount, m_icount);
    check_eq("dcount", dcount, m_dcount);
    check_eq("wait_cycles", wait_cycles, m_wait);
`endif
    @(posedge CLK);
    if (!nRST) begin
      owner    = OWN_NONE;
      m_icount = '0;
      m_dcount = '0;
      m_wait   = '0;
    end else begin
      m_icount = sat_add(m_icount, exp_ihit);
      m_dcount = sat_add(m_dcount, exp_dhit);
      m_wait   = sat_add(m_wait, (owner != OWN_NONE) && !acc);
      if (owner == OWN_NONE) begin
        owner = (dREN || dWEN) ? OWN_D : (iREN ? OWN_I : OWN_NONE);
      end else if (acc) begin
        owner = OWN_NONE;
      end else if (owner == OWN_I && !iREN) begin
        owner = OWN_NONE;
      end else if (owner == OWN_D && !(dREN || dWEN)) begin
        owner = OWN_NONE;
      end
    end
    #1;
  endtask

  initial begin
    int r;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    @(posedge CLK);
    #1;

    // Reset held with a pending fetch and ACCESS on the RAM
    iREN = 1'b1; iaddr = 32'h10; ramstate = ACCESS; ramload = 32'hCAFE_0001;
    repeat (2) cycle();
    nRST = 1'b1;
    repeat (2) cycle();
    iREN = 1'b0;
    cycle();

    // Simultaneous requests: data first, fetch two cycles later
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h40; ramload = 32'hDEAD_BEEF;
    repeat (2) cycle();
    dREN = 1'b0;
    repeat (2) cycle();
    iREN = 1'b0;
    cycle();

    // Write with three wait states
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234; ramstate = BUSY;
    repeat (4) cycle();
    ramstate = ACCESS;
    cycle();
    dWEN = 1'b0; ramstate = FREE;
    cycle();

    // Data request arriving during a fetch grant waits for ihit
    iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY;
    repeat (2) cycle();
    dREN = 1'b1; daddr = 32'h44;
    cycle();
    ramstate = ACCESS;
    cycle();
    iREN = 1'b0;
    repeat (2) cycle();
    dREN = 1'b0;
    cycle();

    // Fetch abort while BUSY
    ramstate = BUSY; iREN = 1'b1; iaddr = 32'h500;
    repeat (2) cycle();
    iREN = 1'b0;
    repeat (2) cycle();

    // Reset in the middle of a data-write grant
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h5;
    repeat (2) cycle();
    nRST = 1'b0;
    cycle();
    nRST = 1'b1; dWEN = 1'b0;
    repeat (2) cycle();

    // Randomized traffic obeying the hold-until-hit protocol
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      ramstate = (r < 5) ? ACCESS : (r < 8) ? BUSY : (r == 8) ? FREE : ERROR;
      ramload  = $urandom;
      nRST     = ($urandom_range(0, 99) != 0);
      if (exp_ihit) iREN = 1'b0;
      if (exp_dhit) begin dREN = 1'b0; dWEN = 1'b0; end
      if (!iREN && $urandom_range(0, 2) == 0) begin
        iREN = 1'b1; iaddr = $urandom;
      end
      if (!dREN && !dWEN && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) dREN = 1'b1; else dWEN = 1'b1;
        daddr = $urandom; dstore = $urandom;
      end
      if (ramstate != ACCESS && $urandom_range(0, 19) == 0) begin
        if (owner == OWN_I) iREN = 1'b0;
        else if (owner == OWN_D) begin dREN = 1'b0; dWEN = 1'b0; end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
